// File: rtl/instr_mem_arbiter_if.sv
// Bus bundle between N_REQ Avalon-MM-style instruction requesters, the
// round-robin arbiter and a single-port instruction memory.
//
// Signals:
//   req_*  : per-requester request side (packed, requester i at [i*W +: W]),
//            plus the shared broadcast read-data bus and per-requester
//            waitrequest / readdatavalid.
//   mem_*  : single memory port driven by the arbiter; mem_readdata returns
//            from the memory one cycle after the address is clocked.
// Modports:
//   slave  : the arbiter (consumes requests, drives the memory port).
//   master : the environment (requesters and memory).
interface instr_mem_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int AW    = 8,
    parameter int DW    = 32
);
    logic [N_REQ*AW-1:0]     req_address;
    logic [N_REQ-1:0]        req_read;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*DW/8-1:0]   req_byteenable;
    logic [N_REQ*DW-1:0]     req_writedata;
    logic [N_REQ-1:0]        req_waitrequest;
    logic [N_REQ-1:0]        req_readdatavalid;
    logic [DW-1:0]           req_readdata;

    logic [AW-1:0]           mem_address;
    logic [DW/8-1:0]         mem_byteenable;
    logic                    mem_chipselect;
    logic                    mem_write;
    logic [DW-1:0]           mem_writedata;
    logic                    mem_clken;
    logic [DW-1:0]           mem_readdata;

    modport slave (
        input  req_address, req_read, req_write, req_byteenable, req_writedata,
        output req_waitrequest, req_readdatavalid, req_readdata,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output req_address, req_read, req_write, req_byteenable, req_writedata,
        input  req_waitrequest, req_readdatavalid, req_readdata,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory between
// N_REQ Avalon-MM-style requesters. One access is granted per cycle; reads
// return one cycle after the grant on a shared data bus, tagged by a
// per-requester readdatavalid. Writes complete in their grant cycle.
//
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : instr_mem_arbiter_if.slave (request side + memory port)
module instr_mem_arbiter #(
    parameter int N_REQ = 2,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_mem_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] active;
    logic [N_REQ-1:0] grant;
    logic             any_grant;
    logic             win_rd;
    logic [PW-1:0]    win_idx;

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    rd_owner_q, rd_owner_d;
    logic             rd_pend_q, rd_pend_d;

    assign active = bus.req_read | bus.req_write;

    // Scan from rr_ptr upward with wrap; first active requester wins.
    // No grant while reset is asserted so every request stalls.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        grant     = '0;
        any_grant = 1'b0;
        win_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(off);
            if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
            idx = sum[PW-1:0];
            if (reset_n && !any_grant && active[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = idx;
            end
        end
    end

    // Read+write together counts as a write: no read response.
    assign win_rd = any_grant & bus.req_read[win_idx] & ~bus.req_write[win_idx];

    always_comb begin
        bus.mem_chipselect = any_grant;
        bus.mem_clken      = any_grant;
        bus.mem_write      = any_grant & bus.req_write[win_idx];
        bus.mem_address    = '0;
        bus.mem_byteenable = '0;
        bus.mem_writedata  = '0;
        if (any_grant) begin
            bus.mem_address    = bus.req_address[win_idx*AW +: AW];
            bus.mem_byteenable = bus.req_byteenable[win_idx*(DW/8) +: (DW/8)];
            bus.mem_writedata  = bus.req_writedata[win_idx*DW +: DW];
        end
    end

    assign bus.req_waitrequest = active & ~grant;
    // The memory holds its address register while idle, so the data bus can
    // be a plain pass-through.
    assign bus.req_readdata    = bus.mem_readdata;

    always_comb begin
        bus.req_readdatavalid = '0;
        for (int i = 0; i < N_REQ; i++)
            bus.req_readdatavalid[i] = rd_pend_q && (rd_owner_q == PW'(i));
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rd_owner_d = rd_owner_q;
        rd_pend_d  = win_rd;
        if (any_grant)
            rr_ptr_d = (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
        if (win_rd)
            rd_owner_d = win_idx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            rd_owner_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_owner_q <= rd_owner_d;
            rd_pend_q  <= rd_pend_d;
        end
    end
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: a 2-requester instance with a
// 256x32 byte-enabled memory model, and a 3-requester instance for the
// pointer-wrap check. Read responses of the 2-requester instance are
// checked against a scoreboard filled as reads are accepted.
module tb_instr_mem_arbiter;
    logic clk;
    logic reset_n;

    instr_mem_arbiter_if #(.N_REQ(2), .AW(8), .DW(32)) bus_a ();
    instr_mem_arbiter_if #(.N_REQ(3), .AW(8), .DW(32)) bus_c ();

    instr_mem_arbiter #(.N_REQ(2), .AW(8), .DW(32)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a));
    instr_mem_arbiter #(.N_REQ(3), .AW(8), .DW(32)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .bus(bus_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model for instance A: registered address, byte-enabled write.
    logic [31:0] mem_a [256];
    logic [7:0]  maddr_a_q;
    always @(posedge clk) begin
        if (bus_a.mem_clken) begin
            if (bus_a.mem_chipselect && bus_a.mem_write)
                for (int b = 0; b < 4; b++)
                    if (bus_a.mem_byteenable[b])
                        mem_a[bus_a.mem_address][b*8 +: 8] <= bus_a.mem_writedata[b*8 +: 8];
            maddr_a_q <= bus_a.mem_address;
        end
    end
    assign bus_a.mem_readdata = mem_a[maddr_a_q];

    // Instance C memory returns its registered address as data.
    logic [7:0] maddr_c_q;
    always @(posedge clk) if (bus_c.mem_clken) maddr_c_q <= bus_c.mem_address;
    assign bus_c.mem_readdata = {24'h0, maddr_c_q};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // Response monitor: every readdatavalid must match the oldest accepted read.
    always @(negedge clk) begin
        exp_t e;
        if (|bus_a.req_readdatavalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {62'h0, bus_a.req_readdatavalid}, 64'h0);
            end else begin
                e = sb.pop_front();
                chk("rd_valid", {62'h0, bus_a.req_readdatavalid}, {62'h0, e.vld});
                chk("rd_data", {32'h0, bus_a.req_readdata}, {32'h0, e.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = 32'h0;
        mem_a[8'h01] = 32'h11111111;
        mem_a[8'h02] = 32'h22222222;
        mem_a[8'h05] = 32'hDEADBEEF;
        mem_a[8'h10] = 32'hAAAAAAAA;
    end

    initial begin
        reset_n = 1'b0;
        bus_a.req_address = '0; bus_a.req_read = '0; bus_a.req_write = '0;
        bus_a.req_byteenable = '1; bus_a.req_writedata = '0;
        bus_c.req_address = '0; bus_c.req_read = '0; bus_c.req_write = '0;
        bus_c.req_byteenable = '1; bus_c.req_writedata = '0;

        // Reset state
        smp();
        chk("rst_rdvalid", {62'h0, bus_a.req_readdatavalid}, 64'h0);
        chk("rst_cs", {63'h0, bus_a.mem_chipselect}, 64'h0);
        chk("rst_wr", {63'h0, bus_a.mem_write}, 64'h0);
        chk("rst_clken", {63'h0, bus_a.mem_clken}, 64'h0);
        bus_a.req_read = 2'b11;
        #1;
        chk("rst_wait", {62'h0, bus_a.req_waitrequest}, 64'h3);
        bus_a.req_read = 2'b00;
        step();
        reset_n = 1'b1;

        // Single read
        bus_a.req_address[7:0] = 8'h05;
        bus_a.req_read = 2'b01;
        smp();
        chk("single_wait", {62'h0, bus_a.req_waitrequest}, 64'h0);
        chk("single_cs", {63'h0, bus_a.mem_chipselect}, 64'h1);
        chk("single_addr", {56'h0, bus_a.mem_address}, 64'h05);
        sb.push_back('{vld: 2'b01, data: 32'hDEADBEEF});
        step();
        bus_a.req_read = 2'b00;
        smp();
        chk("single_cs_drop", {63'h0, bus_a.mem_chipselect}, 64'h0);
        chk("single_valid", {62'h0, bus_a.req_readdatavalid}, 64'h1);

        // Contention from reset: grants alternate 0,1,0,1
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus_a.req_address = {8'h02, 8'h01};
        bus_a.req_read = 2'b11;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("cont_wait", {62'h0, bus_a.req_waitrequest}, (k % 2 == 0) ? 64'h2 : 64'h1);
            if (k % 2 == 0) sb.push_back('{vld: 2'b01, data: 32'h11111111});
            else            sb.push_back('{vld: 2'b10, data: 32'h22222222});
            step();
        end
        bus_a.req_read = 2'b00;
        smp();

        // Byte-enabled write, then read back the merged word
        step();
        bus_a.req_address[15:8] = 8'h10;
        bus_a.req_byteenable[7:4] = 4'b0011;
        bus_a.req_writedata[63:32] = 32'h12345678;
        bus_a.req_write = 2'b10;
        smp();
        chk("wr_wait", {62'h0, bus_a.req_waitrequest}, 64'h0);
        chk("wr_mem_write", {63'h0, bus_a.mem_write}, 64'h1);
        chk("wr_be", {60'h0, bus_a.mem_byteenable}, 64'h3);
        chk("wr_data", {32'h0, bus_a.mem_writedata}, 64'h12345678);
        step();
        bus_a.req_write = 2'b00;
        bus_a.req_byteenable = '1;
        bus_a.req_read = 2'b10;
        smp();
        chk("wr_no_valid", {62'h0, bus_a.req_readdatavalid}, 64'h0);
        sb.push_back('{vld: 2'b10, data: 32'hAAAA5678});
        step();
        bus_a.req_read = 2'b00;
        smp();

        // Reset one cycle after a read grant drops the response
        step();
        bus_a.req_address[7:0] = 8'h05;
        bus_a.req_read = 2'b01;
        smp();
        chk("rmid_wait", {62'h0, bus_a.req_waitrequest}, 64'h0);
        step();
        reset_n = 1'b0;
        smp();
        chk("rmid_no_valid", {62'h0, bus_a.req_readdatavalid}, 64'h0);
        chk("rmid_wait_rst", {62'h0, bus_a.req_waitrequest}, 64'h1);
        chk("rmid_cs", {63'h0, bus_a.mem_chipselect}, 64'h0);
        chk("rmid_clken", {63'h0, bus_a.mem_clken}, 64'h0);
        step();
        bus_a.req_address[15:8] = 8'h02;
        bus_a.req_read = 2'b11;
        smp();
        chk("rmid_wait_both", {62'h0, bus_a.req_waitrequest}, 64'h3);
        step();
        reset_n = 1'b1;
        smp();
        chk("rmid_ptr0", {62'h0, bus_a.req_waitrequest}, 64'h2);
        sb.push_back('{vld: 2'b01, data: 32'hDEADBEEF});
        step();
        bus_a.req_read = 2'b00;
        smp();

        // Read and write together act as a write
        step();
        bus_a.req_address[7:0] = 8'h20;
        bus_a.req_writedata[31:0] = 32'h00000055;
        bus_a.req_read = 2'b01;
        bus_a.req_write = 2'b01;
        smp();
        chk("rw_mem_write", {63'h0, bus_a.mem_write}, 64'h1);
        chk("rw_wait", {62'h0, bus_a.req_waitrequest}, 64'h0);
        step();
        bus_a.req_read = 2'b00;
        bus_a.req_write = 2'b00;
        smp();
        chk("rw_no_valid", {62'h0, bus_a.req_readdatavalid}, 64'h0);

        // Pointer wrap on the 3-requester instance
        step();
        bus_c.req_address[23:16] = 8'h07;
        bus_c.req_read = 3'b100;
        smp();
        chk("wrap_wait0", {61'h0, bus_c.req_waitrequest}, 64'h0);
        chk("wrap_addr0", {56'h0, bus_c.mem_address}, 64'h07);
        step();
        bus_c.req_address = {8'h0C, 8'h0B, 8'h0A};
        bus_c.req_read = 3'b111;
        smp();
        chk("wrap_valid2", {61'h0, bus_c.req_readdatavalid}, 64'h4);
        chk("wrap_data2", {32'h0, bus_c.req_readdata}, 64'h07);
        chk("wrap_g0_wait", {61'h0, bus_c.req_waitrequest}, 64'h6);
        chk("wrap_g0_addr", {56'h0, bus_c.mem_address}, 64'h0A);
        step();
        smp();
        chk("wrap_g1_wait", {61'h0, bus_c.req_waitrequest}, 64'h5);
        chk("wrap_g1_addr", {56'h0, bus_c.mem_address}, 64'h0B);
        chk("wrap_valid0", {61'h0, bus_c.req_readdatavalid}, 64'h1);
        step();
        smp();
        chk("wrap_g2_wait", {61'h0, bus_c.req_waitrequest}, 64'h3);
        chk("wrap_g2_addr", {56'h0, bus_c.mem_address}, 64'h0C);
        step();
        bus_c.req_read = 3'b000;
        smp();
        chk("wrap_valid_last", {61'h0, bus_c.req_readdatavalid}, 64'h4);
        chk("wrap_data_last", {32'h0, bus_c.req_readdata}, 64'h0C);

        step();
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_arbiter.md
Name: instr_mem_arbiter

Overview:
- Shares one single-port 256x32 instruction memory between N_REQ Avalon-MM-style requesters, e.g. the per-core instruction masters and the boot loader of the JPEG MPSoC.
- Grants one access per cycle using round-robin arbitration.
- Drives the memory's address/byteenable/chipselect/write/writedata/clken port.
- Returns read data one cycle after the grant, tagged with a per-requester valid.

Parameters:
N_REQ, 2, number of requesters (2..8)
AW, 8, word address width of the memory
DW, 32, data width; byteenable width is DW/8

Ports:
clk  in  1  single system clock
reset_n  in  1  asynchronous active-low reset
req_address  in  N_REQ*AW  per-requester word address, requester i at [i*AW +: AW]
req_read  in  N_REQ  per-requester read request
req_write  in  N_REQ  per-requester write request
req_byteenable  in  N_REQ*DW/8  per-requester byte enables
req_writedata  in  N_REQ*DW  per-requester write data
req_waitrequest  out  N_REQ  request not accepted this cycle; requester must hold
req_readdatavalid  out  N_REQ  read data for requester i is on req_readdata this cycle
req_readdata  out  DW  shared read-data bus, broadcast to all requesters
mem_address  out  AW  to memory address
mem_byteenable  out  DW/8  to memory byteenable
mem_chipselect  out  1  to memory chipselect
mem_write  out  1  to memory write
mem_writedata  out  DW  to memory writedata
mem_clken  out  1  to memory clock enable
mem_readdata  in  DW  from memory; valid the cycle after the address is clocked

Behaviour:
- Active request from requester i: req_read[i] | req_write[i].
  - If both are high, it is a write; no readdatavalid is produced.
- Arbitration is combinational, round-robin from pointer rr_ptr.
  - The grant goes to the first active requester at index rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - At most one grant per cycle.
- req_waitrequest[i] = active[i] & ~grant[i]. It is 0 when the requester is idle and 0 for the granted requester.
- Memory drive:
  - With a grant: mem_address, mem_byteenable and mem_writedata come from the winner; mem_chipselect = 1; mem_write = winner's write.
  - With no grant: mem_chipselect = 0, mem_write = 0; the other mem_* outputs are don't-care (drive zero).
- mem_clken = 1 in any cycle with a grant, else 0. The memory address register holds while idle, so mem_readdata stays stable.
- rr_ptr update on the clock edge after a grant to i: rr_ptr <= (i+1) mod N_REQ. Unchanged with no grant.
- Read pipeline:
  - On the clock edge of a read grant to i: rd_pend <= 1, rd_owner <= i. Otherwise rd_pend <= 0.
  - req_readdatavalid[i] = rd_pend & (rd_owner == i).
  - req_readdata = mem_readdata, passed through combinationally.
  - Read latency = 1 cycle after the accepting (non-waitrequest) cycle.
  - Back-to-back reads are fully pipelined: 1 read per cycle sustained.
- A write completes in its grant cycle; there is no response phase.
- A read immediately after a write to the same address from any requester returns the new data.
- Reset (asynchronous, active-low):
  - rr_ptr = 0, rd_pend = 0, rd_owner = 0.
  - All req_readdatavalid = 0; mem_chipselect/mem_write/mem_clken = 0, since no request is granted while reset_n = 0.
  - req_waitrequest = active while in reset, so every request stalls.
- Reset asserted while a read is pending: the readdatavalid is dropped. The requester must reissue after reset.
- A requester whose request is held under waitrequest must keep address/data stable. The arbiter does not latch them.
- Worst-case wait for a continuously asserting requester is N_REQ-1 cycles (no starvation).

Test Plan:
- Single read: requester 0 reads address 0x05 (memory preloaded with 0xDEADBEEF). Required: waitrequest 0 in the same cycle; next cycle req_readdatavalid = 2'b01 with req_readdata = 0xDEADBEEF; mem_chipselect high for exactly 1 cycle.
- Contention: both requesters read continuously from reset (rr_ptr = 0), requester 0 at addr 1, requester 1 at addr 2. Required: grants alternate 0,1,0,1; each waitrequest is high on alternate cycles; readdatavalid alternates 01,10 starting 1 cycle after the first grant.
- Write then read: requester 1 writes 0x12345678 to 0x10 with byteenable 4'b0011, then reads 0x10 (prior contents 0xAAAAAAAA). Required: read returns 0xAAAA5678; no readdatavalid for the write cycle.
- Wrap/pointer: N_REQ = 3, only requester 2 active for 1 access, then all three active. Required: rr_ptr wraps to 0; grant order is 0,1,2.
- Reset mid-read: assert reset_n = 0 one cycle after requester 0's read is granted. Required: req_readdatavalid stays 0; after release, rr_ptr = 0 and a new read completes normally.
- Read+write simultaneous: requester 0 asserts read and write together. Required: mem_write = 1; no readdatavalid follows.
